mmu_xlat: RTL and testbench
===========================

Name: mmu_xlat

Overview:
- Parametrised MIPS32 virtual-to-physical translation unit. It is the successor to the combinational fixed-segment mapper.
- Adds an N-entry fully-associative joint TLB with ASID/global matching, 4 KB even/odd page pairs, a TLBP probe and TLBWI/TLBWR write port.
- Adds a registered valid/ready request/response stage with exception reporting.
- Sits between the IF/MEM address generation and the cache/bus front end.

Parameters:
- TLB_ENTRIES, 8, number of TLB entries; power of 2, range 2..32.
- IDX_W, $clog2(TLB_ENTRIES), TLB index width.
- ASID_W, 8, address-space ID width.
- PADDR_W, 32, physical address width; must be at least 29. PFN width = PADDR_W-12.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  translation request.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_vaddr  in  32  virtual address.
- req_store  in  1  access is a store (used for dirty check).
- cur_asid  in  ASID_W  current ASID (EntryHi.ASID), sampled on accept.
- erl  in  1  Status.ERL; when 1, kuseg is unmapped identity.
- k0_cca  in  3  Config.K0; value 2 means uncached.
- resp_valid  out  1  response held until resp_ready.
- resp_ready  in  1  consumer accepts the response.
- resp_paddr  out  PADDR_W  physical address.
- resp_uncached  out  1  access must bypass caches.
- resp_exc  out  2  0 none, 1 refill/miss, 2 invalid, 3 modified.
- tlbw_en  in  1  write one entry.
- tlbw_idx  in  IDX_W  target entry.
- tlbw_vpn2  in  19  VPN2 (vaddr[31:13]).
- tlbw_asid  in  ASID_W  entry ASID.
- tlbw_g  in  1  global bit.
- tlbw_lo0  in  PADDR_W-12+5  even page {PFN,C[2:0],D,V}.
- tlbw_lo1  in  PADDR_W-12+5  odd page, same format.
- tlbp_en  in  1  probe request.
- tlbp_vpn2  in  19  probe VPN2.
- tlbp_asid  in  ASID_W  probe ASID.
- tlbp_done  out  1  one-cycle pulse, the cycle after tlbp_en.
- tlbp_miss  out  1  no entry matched (Index.P).
- tlbp_idx  out  IDX_W  lowest matching index.

Behaviour:
- Reset: all entry valid-tags cleared, so no entry matches until written. Reset values: resp_valid=0, resp_paddr=0, resp_uncached=0, resp_exc=0, tlbp_done=0, tlbp_miss=0, tlbp_idx=0. req_ready=1 the cycle after reset.
- Reset mid-operation discards a pending response; no resp_valid is produced for it.
- Handshake: req_ready = !resp_valid || resp_ready. Latency is exactly 1 cycle from accept to resp_valid. Back-to-back accepts give 1 response/cycle.
- resp_* are stable while resp_valid && !resp_ready.
- Segment decode on vaddr[31:29]:
  - kuseg 0xx, with erl=0 → mapped. With erl=1 → paddr = vaddr zero-extended, cached per k0_cca.
  - kseg0 100 → paddr = {0, vaddr[28:0]}, uncached = (k0_cca==2).
  - kseg1 101 → paddr = {0, vaddr[28:0]}, uncached = 1.
  - kseg2/kseg3 11x → mapped.
- Unmapped segments never raise an exception.
- Mapped lookup:
  - Entry i matches if vpn2[i]==vaddr[31:13] and (g[i] || asid[i]==cur_asid) and the entry has been written since reset.
  - Multiple matches: lowest index wins.
  - vaddr[12] selects lo1 (1) or lo0 (0).
  - paddr = {PFN, vaddr[11:0]}; uncached = (C==2).
- Exception priority: no match → 1; V=0 → 2; req_store && D=0 → 3.
- On any exception, resp_paddr = 0 and resp_uncached = 0.
- Write/lookup collision: a TLB write in cycle t affects requests accepted in cycle t+1 onward. A request accepted in cycle t sees the old contents. Writes are never stalled.
- Probe: uses the same match logic as lookup. Results are registered and valid in the tlbp_done cycle; they reflect contents before any write issued in the same cycle. Probe and request may be issued in the same cycle.
- tlbw_idx ≥ TLB_ENTRIES (non-power-of-2 misuse) is ignored.

Optional Feature:
- Macro MMU_FIXED_MAP_EN.
- Defined: legacy bring-up mode.
  - kuseg, kseg2 and kseg3 are identity-mapped (paddr = vaddr zero-extended, uncached=0, exc=0), ignoring the TLB.
  - kseg0/kseg1 are unchanged.
  - TLB storage and probe remain functional.
- Undefined: full mapped behaviour as above.

Test Plan:
- Reset, then req 0x8000_1234, k0_cca=3 → next cycle resp_valid=1, paddr=0x0000_1234, uncached=0, exc=0. Same address with k0_cca=2 → uncached=1.
- Req 0xBFC0_0000 → paddr=0x1FC0_0000, uncached=1, exc=0. Req 0x0040_0000 with an empty TLB → exc=1, paddr=0.
- Write idx 3 with vpn2=0x00200, asid=5, g=0, lo0={PFN 0x12345,C=3,D=1,V=1}, lo1={PFN 0x0ABCD,C=2,D=0,V=1}. Then with cur_asid=5:
  - req 0x0040_0010 → paddr 0x1234_5010, uncached=0.
  - req 0x0040_1020 → paddr 0x0ABC_D020, uncached=1.
  - store to 0x0040_1020 → exc=3.
  - cur_asid=6 → exc=1.
- Invalid page: set lo0 V=0 → exc=2.
- Duplicate entries at idx 1 and idx 3 → idx 1 result used. tlbp on the same VPN2 → tlbp_done pulse, tlbp_miss=0, tlbp_idx=1.
- Stall: hold resp_ready=0 for 3 cycles with req_valid=1 → req_ready=0 and response stable. Release → next response 1 cycle later; no loss or duplication.
- Write idx 3 in the same cycle a matching request is accepted → that response uses the old entry; the request accepted the following cycle uses the new entry.

Source files
------------

// File: rtl/mmu_xlat.sv
// Purpose : MIPS32 virtual-to-physical translation with an N-entry fully-associative joint TLB
//           (ASID/global match, 4 KB even/odd page pairs), TLBP probe and TLBWI/TLBWR write port.
// Latency : 1 cycle from request accept to resp_valid; probe results 1 cycle after tlbp_en.
// Backpr. : req_ready = !resp_valid || resp_ready; response held stable until consumed; writes never stall.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   req_*               - valid/ready translation request (vaddr, store flag)
//   cur_asid, erl, k0_cca - address-space ID, Status.ERL, Config.K0, all sampled on accept
//   resp_*              - registered response: paddr, uncached, exc (0 none, 1 refill, 2 invalid, 3 modified)
//   tlbw_*              - single-entry write port, lo format {PFN, C[2:0], D, V}
//   tlbp_*              - probe request and registered result (done pulse, miss, lowest index)
//
// Optional: define MMU_FIXED_MAP_EN for legacy bring-up mode, where kuseg/kseg2/kseg3 are
//           identity-mapped and the TLB is bypassed for requests (storage and probe still work).

module mmu_xlat #(
  parameter int TLB_ENTRIES = 8,
  parameter int IDX_W       = $clog2(TLB_ENTRIES),
  parameter int ASID_W      = 8,
  parameter int PADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // request
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_vaddr,
  input  logic                    req_store,
  input  logic [ASID_W-1:0]       cur_asid,
  input  logic                    erl,
  input  logic [2:0]              k0_cca,
  // response
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [PADDR_W-1:0]      resp_paddr,
  output logic                    resp_uncached,
  output logic [1:0]              resp_exc,
  // TLB write
  input  logic                    tlbw_en,
  input  logic [IDX_W-1:0]        tlbw_idx,
  input  logic [18:0]             tlbw_vpn2,
  input  logic [ASID_W-1:0]       tlbw_asid,
  input  logic                    tlbw_g,
  input  logic [PADDR_W-12+5-1:0] tlbw_lo0,
  input  logic [PADDR_W-12+5-1:0] tlbw_lo1,
  // TLB probe
  input  logic                    tlbp_en,
  input  logic [18:0]             tlbp_vpn2,
  input  logic [ASID_W-1:0]       tlbp_asid,
  output logic                    tlbp_done,
  output logic                    tlbp_miss,
  output logic [IDX_W-1:0]        tlbp_idx
);

  localparam int PFN_W = PADDR_W - 12;
  localparam int LO_W  = PFN_W + 5;

  localparam logic [1:0] EXC_NONE   = 2'd0;
  localparam logic [1:0] EXC_REFILL = 2'd1;
  localparam logic [1:0] EXC_INVAL  = 2'd2;
  localparam logic [1:0] EXC_MOD    = 2'd3;

  localparam logic [2:0] CCA_UNCACHED = 3'd2;

  typedef struct packed {
    logic              vld;   // written since reset
    logic [18:0]       vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [LO_W-1:0]   lo0;
    logic [LO_W-1:0]   lo1;
  } tlb_entry_t;

  // ---------------------------------------------------------------------------
  // TLB storage
  // ---------------------------------------------------------------------------
  tlb_entry_t tlb_q [TLB_ENTRIES];
  tlb_entry_t tlb_d [TLB_ENTRIES];

  always_comb begin
    tlb_d = tlb_q;
    // Out-of-range indices can only occur for non-power-of-2 sizes; drop them.
    if (tlbw_en && (int'(tlbw_idx) < TLB_ENTRIES)) begin
      tlb_d[tlbw_idx] = '{vld:  1'b1,
                          vpn2: tlbw_vpn2,
                          asid: tlbw_asid,
                          g:    tlbw_g,
                          lo0:  tlbw_lo0,
                          lo1:  tlbw_lo1};
    end
  end

  // ---------------------------------------------------------------------------
  // Match logic: request and probe both read tlb_q, so a write in the same
  // cycle is only visible from the following cycle onward.
  // ---------------------------------------------------------------------------
  function automatic logic [IDX_W-1:0] first_hit(input logic [TLB_ENTRIES-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    // Walk downward so the lowest matching index is the last one assigned.
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  logic [TLB_ENTRIES-1:0] req_match;
  logic [TLB_ENTRIES-1:0] prb_match;

  always_comb begin
    req_match = '0;
    prb_match = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      req_match[i] = tlb_q[i].vld && (tlb_q[i].vpn2 == req_vaddr[31:13]) &&
                     (tlb_q[i].g || (tlb_q[i].asid == cur_asid));
      prb_match[i] = tlb_q[i].vld && (tlb_q[i].vpn2 == tlbp_vpn2) &&
                     (tlb_q[i].g || (tlb_q[i].asid == tlbp_asid));
    end
  end

  logic             req_hit;
  logic [IDX_W-1:0] req_idx;
  tlb_entry_t       hit_ent;
  logic [LO_W-1:0]  page;
  logic [PFN_W-1:0] pg_pfn;
  logic [2:0]       pg_c;
  logic             pg_d;
  logic             pg_v;

  always_comb begin
    req_hit = |req_match;
    req_idx = first_hit(req_match);
    hit_ent = tlb_q[req_idx];
    // vaddr[12] picks the odd (lo1) or even (lo0) page of the pair.
    page    = req_vaddr[12] ? hit_ent.lo1 : hit_ent.lo0;
    pg_pfn  = page[LO_W-1:5];
    pg_c    = page[4:2];
    pg_d    = page[1];
    pg_v    = page[0];
  end

  // ---------------------------------------------------------------------------
  // Segment decode and translation result
  // ---------------------------------------------------------------------------
  logic [PADDR_W-1:0] xl_paddr;
  logic               xl_unc;
  logic [1:0]         xl_exc;

  always_comb begin
    xl_paddr = '0;
    xl_unc   = 1'b0;
    xl_exc   = EXC_NONE;
    if (req_vaddr[31:29] == 3'b100) begin
      // kseg0: unmapped, cacheability from Config.K0
      xl_paddr = PADDR_W'({3'b000, req_vaddr[28:0]});
      xl_unc   = (k0_cca == CCA_UNCACHED);
    end else if (req_vaddr[31:29] == 3'b101) begin
      // kseg1: unmapped, always uncached
      xl_paddr = PADDR_W'({3'b000, req_vaddr[28:0]});
      xl_unc   = 1'b1;
    end
`ifdef MMU_FIXED_MAP_EN
    else begin
      // Bring-up mode: every other segment is a cached identity map.
      xl_paddr = PADDR_W'(req_vaddr);
    end
`else
    else if (!req_vaddr[31] && erl) begin
      // kuseg under error level is an identity map, cached per K0.
      xl_paddr = PADDR_W'(req_vaddr);
      xl_unc   = (k0_cca == CCA_UNCACHED);
    end else if (!req_hit) begin
      xl_exc = EXC_REFILL;
    end else if (!pg_v) begin
      xl_exc = EXC_INVAL;
    end else if (req_store && !pg_d) begin
      xl_exc = EXC_MOD;
    end else begin
      xl_paddr = {pg_pfn, req_vaddr[11:0]};
      xl_unc   = (pg_c == CCA_UNCACHED);
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Response register stage
  // ---------------------------------------------------------------------------
  logic               resp_valid_q, resp_valid_d;
  logic [PADDR_W-1:0] resp_paddr_q, resp_paddr_d;
  logic               resp_unc_q,   resp_unc_d;
  logic [1:0]         resp_exc_q,   resp_exc_d;
  logic               accept;

  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_paddr_d = resp_paddr_q;
    resp_unc_d   = resp_unc_q;
    resp_exc_d   = resp_exc_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_paddr_d = xl_paddr;
      resp_unc_d   = xl_unc;
      resp_exc_d   = xl_exc;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Probe result register
  // ---------------------------------------------------------------------------
  logic             tlbp_done_q, tlbp_done_d;
  logic             tlbp_miss_q, tlbp_miss_d;
  logic [IDX_W-1:0] tlbp_idx_q,  tlbp_idx_d;

  always_comb begin
    tlbp_done_d = tlbp_en;
    tlbp_miss_d = tlbp_miss_q;
    tlbp_idx_d  = tlbp_idx_q;
    if (tlbp_en) begin
      tlbp_miss_d = ~|prb_match;
      tlbp_idx_d  = first_hit(prb_match);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tlb_q[i] <= '0;
      end
      resp_valid_q <= 1'b0;
      resp_paddr_q <= '0;
      resp_unc_q   <= 1'b0;
      resp_exc_q   <= EXC_NONE;
      tlbp_done_q  <= 1'b0;
      tlbp_miss_q  <= 1'b0;
      tlbp_idx_q   <= '0;
    end else begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tlb_q[i] <= tlb_d[i];
      end
      resp_valid_q <= resp_valid_d;
      resp_paddr_q <= resp_paddr_d;
      resp_unc_q   <= resp_unc_d;
      resp_exc_q   <= resp_exc_d;
      tlbp_done_q  <= tlbp_done_d;
      tlbp_miss_q  <= tlbp_miss_d;
      tlbp_idx_q   <= tlbp_idx_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_paddr    = resp_paddr_q;
  assign resp_uncached = resp_unc_q;
  assign resp_exc      = resp_exc_q;
  assign tlbp_done     = tlbp_done_q;
  assign tlbp_miss     = tlbp_miss_q;
  assign tlbp_idx      = tlbp_idx_q;

endmodule

// File: tb/tb_mmu_xlat.sv
// Purpose : self-checking bench for mmu_xlat (default build) using a response scoreboard.
// Latency : expects each accepted request to produce its response exactly one cycle later.
// Backpr. : exercises resp_ready stalls, back-to-back accepts and reset with a pending response.

module tb_mmu_xlat;

  localparam int N       = 8;
  localparam int IDX_W   = 3;
  localparam int ASID_W  = 8;
  localparam int PADDR_W = 32;
  localparam int LO_W    = PADDR_W - 12 + 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_store, erl;
  logic [31:0]       req_vaddr;
  logic [ASID_W-1:0] cur_asid;
  logic [2:0]        k0_cca;
  logic              resp_valid, resp_ready, resp_uncached;
  logic [PADDR_W-1:0] resp_paddr;
  logic [1:0]        resp_exc;
  logic              tlbw_en, tlbw_g;
  logic [IDX_W-1:0]  tlbw_idx;
  logic [18:0]       tlbw_vpn2;
  logic [ASID_W-1:0] tlbw_asid;
  logic [LO_W-1:0]   tlbw_lo0, tlbw_lo1;
  logic              tlbp_en, tlbp_done, tlbp_miss;
  logic [18:0]       tlbp_vpn2;
  logic [ASID_W-1:0] tlbp_asid;
  logic [IDX_W-1:0]  tlbp_idx;

  always #5 clk = ~clk;

  mmu_xlat #(
    .TLB_ENTRIES(N), .IDX_W(IDX_W), .ASID_W(ASID_W), .PADDR_W(PADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_store(req_store), .cur_asid(cur_asid), .erl(erl), .k0_cca(k0_cca),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_uncached(resp_uncached), .resp_exc(resp_exc),
    .tlbw_en(tlbw_en), .tlbw_idx(tlbw_idx), .tlbw_vpn2(tlbw_vpn2),
    .tlbw_asid(tlbw_asid), .tlbw_g(tlbw_g), .tlbw_lo0(tlbw_lo0), .tlbw_lo1(tlbw_lo1),
    .tlbp_en(tlbp_en), .tlbp_vpn2(tlbp_vpn2), .tlbp_asid(tlbp_asid),
    .tlbp_done(tlbp_done), .tlbp_miss(tlbp_miss), .tlbp_idx(tlbp_idx)
  );

  typedef struct packed {
    logic [31:0] paddr;
    logic        unc;
    logic [1:0]  exc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;
  int   n_pop   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: one scoreboard entry per cycle with resp_valid && resp_ready.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        check("spurious_resp", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        n_pop++;
        check("resp_paddr", resp_paddr, mon_e.paddr);
        check("resp_uncached", resp_uncached, mon_e.unc);
        check("resp_exc", resp_exc, mon_e.exc);
      end
    end
  end

  function automatic logic [LO_W-1:0] lo(input logic [19:0] pfn, input logic [2:0] c,
                                         input logic d, input logic v);
    return {pfn, c, d, v};
  endfunction

  // Drive one request (called at posedge+1), wait for acceptance, push its expectation.
  // Leaves req_valid high so consecutive calls give back-to-back accepts.
  task automatic send(input logic [31:0] va, input logic st, input logic [7:0] asid,
                      input logic e, input logic [2:0] cca,
                      input logic [31:0] pa, input logic u, input logic [1:0] x);
    bit ok;
    req_valid = 1'b1; req_vaddr = va; req_store = st;
    cur_asid  = asid; erl = e; k0_cca = cca;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      else @(posedge clk);
    end
    if (ok) begin
      sb.push_back('{paddr: pa, unc: u, exc: x});
      n_push++;
      @(posedge clk); #1;
      check("latency_1cyc", resp_valid, 64'd1);
    end else begin
      check("req_accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_wr(input logic [IDX_W-1:0] idx, input logic [18:0] vpn2,
                        input logic [7:0] asid, input logic g,
                        input logic [LO_W-1:0] l0, input logic [LO_W-1:0] l1);
    tlbw_en = 1'b1; tlbw_idx = idx; tlbw_vpn2 = vpn2;
    tlbw_asid = asid; tlbw_g = g; tlbw_lo0 = l0; tlbw_lo1 = l1;
  endtask

  task automatic tlbw(input logic [IDX_W-1:0] idx, input logic [18:0] vpn2,
                      input logic [7:0] asid, input logic g,
                      input logic [LO_W-1:0] l0, input logic [LO_W-1:0] l1);
    set_wr(idx, vpn2, asid, g, l0, l1);
    @(posedge clk); #1;
    tlbw_en = 1'b0;
  endtask

  task automatic probe(input logic [18:0] vpn2, input logic [7:0] asid,
                       input logic exp_miss, input logic [IDX_W-1:0] exp_idx);
    tlbp_en = 1'b1; tlbp_vpn2 = vpn2; tlbp_asid = asid;
    @(posedge clk); #1;
    tlbp_en = 1'b0;
    check("tlbp_done", tlbp_done, 64'd1);
    check("tlbp_miss", tlbp_miss, exp_miss);
    if (!exp_miss) check("tlbp_idx", tlbp_idx, exp_idx);
    @(posedge clk); #1;
    check("tlbp_done_pulse", tlbp_done, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_store = 1'b0;
    cur_asid = '0; erl = 1'b0; k0_cca = 3'd3; resp_ready = 1'b1;
    tlbw_en = 1'b0; tlbw_idx = '0; tlbw_vpn2 = '0; tlbw_asid = '0; tlbw_g = 1'b0;
    tlbw_lo0 = '0; tlbw_lo1 = '0; tlbp_en = 1'b0; tlbp_vpn2 = '0; tlbp_asid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_resp_valid", resp_valid, 64'd0);
    check("rst_resp_paddr", resp_paddr, 64'd0);
    check("rst_resp_unc", resp_uncached, 64'd0);
    check("rst_resp_exc", resp_exc, 64'd0);
    check("rst_tlbp_done", tlbp_done, 64'd0);
    check("rst_tlbp_miss", tlbp_miss, 64'd0);
    check("rst_tlbp_idx", tlbp_idx, 64'd0);
    check("rst_req_ready", req_ready, 64'd1);

    // Unmapped segments and empty-TLB miss, issued back-to-back
    send(32'h8000_1234, 0, 8'd0, 0, 3'd3, 32'h0000_1234, 0, 2'd0);
    send(32'h8000_1234, 0, 8'd0, 0, 3'd2, 32'h0000_1234, 1, 2'd0);
    send(32'hBFC0_0000, 0, 8'd0, 0, 3'd3, 32'h1FC0_0000, 1, 2'd0);
    send(32'h0040_0000, 0, 8'd0, 0, 3'd3, 32'h0000_0000, 0, 2'd1);
    send(32'h0040_0000, 0, 8'd0, 1, 3'd2, 32'h0040_0000, 1, 2'd0);
    idle(2);

    // Mapped kuseg through entry 3
    tlbw(3'd3, 19'h00200, 8'd5, 1'b0, lo(20'h12345, 3'd3, 1, 1), lo(20'h0ABCD, 3'd2, 0, 1));
    send(32'h0040_0010, 0, 8'd5, 0, 3'd3, 32'h1234_5010, 0, 2'd0);
    send(32'h0040_1020, 0, 8'd5, 0, 3'd3, 32'h0ABC_D020, 1, 2'd0);
    send(32'h0040_1020, 1, 8'd5, 0, 3'd3, 32'h0000_0000, 0, 2'd3);
    send(32'h0040_0010, 0, 8'd6, 0, 3'd3, 32'h0000_0000, 0, 2'd1);
    send(32'h0040_0010, 1, 8'd5, 0, 3'd3, 32'h1234_5010, 0, 2'd0);
    idle(2);

    // Mapped kseg2 through a global entry
    tlbw(3'd0, 19'h60000, 8'd9, 1'b1, lo(20'h00777, 3'd3, 1, 1), lo(20'h00888, 3'd3, 1, 0));
    send(32'hC000_0ABC, 0, 8'd2, 0, 3'd3, 32'h0077_7ABC, 0, 2'd0);
    send(32'hC000_1000, 0, 8'd2, 0, 3'd3, 32'h0000_0000, 0, 2'd2);
    idle(2);

    // Invalid even page
    tlbw(3'd3, 19'h00200, 8'd5, 1'b0, lo(20'h12345, 3'd3, 1, 0), lo(20'h0ABCD, 3'd2, 0, 1));
    send(32'h0040_0010, 0, 8'd5, 0, 3'd3, 32'h0000_0000, 0, 2'd2);
    idle(2);

    // Duplicate at idx 1: lowest index wins for lookup and probe
    tlbw(3'd1, 19'h00200, 8'd5, 1'b0, lo(20'h55555, 3'd3, 1, 1), lo(20'h66666, 3'd3, 1, 1));
    send(32'h0040_0010, 0, 8'd5, 0, 3'd3, 32'h5555_5010, 0, 2'd0);
    idle(2);
    probe(19'h00200, 8'd5, 1'b0, 3'd1);
    probe(19'h12345, 8'd5, 1'b1, 3'd0);

    // Stall: response held while resp_ready is low, then released
    resp_ready = 1'b0;
    send(32'h8000_0100, 0, 8'd0, 0, 3'd3, 32'h0000_0100, 0, 2'd0);
    req_vaddr = 32'hA000_0200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_ready", req_ready, 64'd0);
      check("stall_resp_valid", resp_valid, 64'd1);
      check("stall_resp_paddr", resp_paddr, 64'h0000_0100);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    send(32'hA000_0200, 0, 8'd0, 0, 3'd3, 32'h0000_0200, 1, 2'd0);
    idle(2);

    // Write/lookup collision on entry 3 (idx 1 retargeted so entry 3 is the only hit)
    tlbw(3'd1, 19'h7FFFF, 8'd0, 1'b0, lo(20'h0, 3'd3, 1, 1), lo(20'h0, 3'd3, 1, 1));
    tlbw(3'd3, 19'h00200, 8'd5, 1'b0, lo(20'h12345, 3'd3, 1, 1), lo(20'h0ABCD, 3'd2, 0, 1));
    set_wr(3'd3, 19'h00200, 8'd5, 1'b0, lo(20'h2468A, 3'd3, 1, 1), lo(20'h0ABCD, 3'd2, 0, 1));
    send(32'h0040_0010, 0, 8'd5, 0, 3'd3, 32'h1234_5010, 0, 2'd0);
    tlbw_en = 1'b0;
    send(32'h0040_0010, 0, 8'd5, 0, 3'd3, 32'h2468_A010, 0, 2'd0);
    idle(2);

    // Reset with a pending response: it must vanish and the TLB must be empty
    resp_ready = 1'b0;
    send(32'h8000_0040, 0, 8'd0, 0, 3'd3, 32'h0000_0040, 0, 2'd0);
    void'(sb.pop_back());
    n_push--;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_resp_valid", resp_valid, 64'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    check("midrst_resp_valid2", resp_valid, 64'd0);
    @(posedge clk); #1;
    send(32'h0040_0010, 0, 8'd5, 0, 3'd3, 32'h0000_0000, 0, 2'd1);
    idle(3);

    check("sb_empty", sb.size(), 64'd0);
    check("resp_count", n_pop, n_push);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
